// File: rtl/key_pkg.sv
// Shared definitions for the matrix keypad scanner: debounce states, sweep
// results, column strobe constants and the key code width.
package key_pkg;

    localparam int KEY_W = 4;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } deb_state_e;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        KEY   = 2'd1,
        MULTI = 2'd2
    } sweep_res_e;

    localparam logic [3:0] COL0 = 4'b1110;
    localparam logic [3:0] COL1 = 4'b1101;
    localparam logic [3:0] COL2 = 4'b1011;
    localparam logic [3:0] COL3 = 4'b0111;

    // Column number of an active-low one-cold strobe.
    function automatic logic [1:0] col_index(input logic [3:0] sel);
        case (sel)
            COL1:    return 2'd1;
            COL2:    return 2'd2;
            COL3:    return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Sweep-level debounce: confirms a press after DEBOUNCE identical sweeps and a
// release after DEBOUNCE clean sweeps; one-clock key_valid per confirmed press.
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             eval_i,
    input  sweep_res_e       res_i,
    input  logic [KEY_W-1:0] res_key_i,
    output logic [KEY_W-1:0] key_code_o,
    output logic             key_valid_o,
    output logic             key_held_o,
    output deb_state_e       state_o
);

    localparam logic [3:0] DEB = 4'(DEBOUNCE);

    deb_state_e       state_q, state_d;
    logic [KEY_W-1:0] cand_q, cand_d;
    logic [KEY_W-1:0] code_q, code_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic [3:0]       cnt_inc;
    logic             is_key;

    assign cnt_inc = cnt_q + 4'd1;
    assign is_key  = (res_i == KEY);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cand_q  <= '0;
            code_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        if (eval_i) begin
            case (state_q)
                IDLE: begin
                    if (is_key) begin
                        if (DEBOUNCE == 1) begin
                            state_d = HELD;
                            code_d  = res_key_i;
                            valid_d = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            state_d = PRESS_WAIT;
                            cand_d  = res_key_i;
                            cnt_d   = 4'd1;
                        end
                    end
                end
                PRESS_WAIT: begin
                    if (is_key && res_key_i == cand_q) begin
                        if (cnt_inc == DEB) begin
                            state_d = HELD;
                            code_d  = cand_q;
                            valid_d = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else if (is_key) begin
                        cand_d = res_key_i;
                        cnt_d  = 4'd1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                HELD: begin
                    // A different key only starts a release; it is never reported.
                    if (!(is_key && res_key_i == code_q)) begin
                        if (!is_key && DEBOUNCE == 1) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            state_d = RELEASE_WAIT;
                            cnt_d   = 4'd1;
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (is_key) begin
                        state_d = HELD;
                        cnt_d   = '0;
                    end else if (cnt_inc == DEB) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        key_code_o  = code_q;
        key_valid_o = valid_q;
        key_held_o  = (state_q == HELD) || (state_q == RELEASE_WAIT);
        state_o     = state_q;
    end

endmodule

// File: rtl/key_scan.sv
// 4x4 keypad scanner: row synchronizer, column dwell/rotation and per-sweep
// key accumulation feeding the debounce FSM.
module key_scan
    import key_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic             CLK_key,
    input  logic             RST_n,
    input  logic [3:0]       row_in,
    output logic [3:0]       col_sel,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             key_held,
    output deb_state_e       dbg_state
);

    localparam int             DW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);

    logic [3:0]       sync1_q, sync2_q;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic [3:0]       col_q, col_d;
    logic             acc_have_q, acc_have_d;
    logic             acc_multi_q, acc_multi_d;
    logic [KEY_W-1:0] acc_key_q, acc_key_d;

    logic             tick, eval;
    logic [3:0]       row_low;
    logic [2:0]       n_low;
    logic [1:0]       row_idx;
    logic             samp_one, samp_multi;
    logic             sweep_have, sweep_multi;
    logic [KEY_W-1:0] sweep_key;
    sweep_res_e       sweep_res;

    always_ff @(posedge CLK_key or negedge RST_n) begin
        if (!RST_n) begin
            sync1_q     <= 4'hF;
            sync2_q     <= 4'hF;
            dwell_q     <= '0;
            col_q       <= COL0;
            acc_have_q  <= 1'b0;
            acc_multi_q <= 1'b0;
            acc_key_q   <= '0;
        end else begin
            sync1_q     <= row_in;
            sync2_q     <= sync1_q;
            dwell_q     <= dwell_d;
            col_q       <= col_d;
            acc_have_q  <= acc_have_d;
            acc_multi_q <= acc_multi_d;
            acc_key_q   <= acc_key_d;
        end
    end

    // Classify the current column sample and fold it into the running sweep.
    always_comb begin
        row_low = ~sync2_q;
        n_low   = '0;
        row_idx = '0;
        for (int r = 0; r < 4; r++) begin
            if (row_low[r]) begin
                n_low   = n_low + 3'd1;
                row_idx = 2'(r);
            end
        end
        samp_one    = (n_low == 3'd1);
        samp_multi  = (n_low >= 3'd2);
        sweep_multi = acc_multi_q || samp_multi || (acc_have_q && samp_one);
        sweep_have  = acc_have_q || samp_one;
        sweep_key   = samp_one ? {row_idx, col_index(col_q)} : acc_key_q;
        if (sweep_multi) begin
            sweep_res = MULTI;
        end else if (sweep_have) begin
            sweep_res = KEY;
        end else begin
            sweep_res = NONE;
        end
    end

    always_comb begin
        tick        = (dwell_q == DWELL_LAST);
        eval        = tick && (col_q == COL3);
        dwell_d     = tick ? '0 : dwell_q + DW'(1);
        col_d       = tick ? {col_q[2:0], col_q[3]} : col_q;
        acc_have_d  = acc_have_q;
        acc_multi_d = acc_multi_q;
        acc_key_d   = acc_key_q;
        if (eval) begin
            acc_have_d  = 1'b0;
            acc_multi_d = 1'b0;
            acc_key_d   = '0;
        end else if (tick) begin
            acc_have_d  = sweep_have;
            acc_multi_d = sweep_multi;
            acc_key_d   = sweep_key;
        end
    end

    assign col_sel = col_q;

    key_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk_i       (CLK_key),
        .rst_ni      (RST_n),
        .eval_i      (eval),
        .res_i       (sweep_res),
        .res_key_i   (sweep_key),
        .key_code_o  (key_code),
        .key_valid_o (key_valid),
        .key_held_o  (key_held),
        .state_o     (dbg_state)
    );

endmodule

// File: tb/tb_key_scan.sv
// Bench for key_scan: a keypad model drives the rows from the column strobe,
// and a sweep-level reference model predicts every output each clock.
module tb_key_scan;

    localparam int SD    = 4;
    localparam int DEB   = 3;
    localparam int SWEEP = 4 * SD;

    logic                 clk_key = 1'b0;
    logic                 rst_n   = 1'b1;
    logic [15:0]          keys    = '0;
    logic [3:0]           row_in;
    logic [3:0]           col_sel;
    logic [3:0]           key_code;
    logic                 key_valid;
    logic                 key_held;
    key_pkg::deb_state_e  dbg_state;

    int n_pass  = 0;
    int n_total = 0;

    key_scan #(.SCAN_DIV(SD), .DEBOUNCE(DEB)) dut (
        .CLK_key   (clk_key),
        .RST_n     (rst_n),
        .row_in    (row_in),
        .col_sel   (col_sel),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial forever #5 clk_key = ~clk_key;

    // keypad: pressed key r*4+c pulls row r low while column c is strobed
    always_comb begin
        for (int r = 0; r < 4; r++) row_in[r] = ~|(keys[r*4 +: 4] & ~col_sel);
    end

    // reference model, evaluated per sweep
    int          m_e;
    logic [15:0] m_p1, m_p2;
    int          m_sweep[$];
    bit          m_multi;
    int          m_streak_key, m_streak_len, m_rel;
    bit          m_held;
    logic [3:0]  exp_code;
    bit          exp_valid;
    logic [3:0]  exp_colsel;
    int          m_confirms = 0;
    logic [3:0]  exp_q[$];

    task automatic model_reset();
        m_e = 0; m_p1 = '0; m_p2 = '0; m_sweep.delete(); m_multi = 0;
        m_streak_key = 0; m_streak_len = 0; m_rel = 0; m_held = 0;
        exp_code = '0; exp_valid = 0; exp_colsel = 4'b1110; exp_q.delete();
    endtask

    task automatic model_sweep_done();
        bit is_key;
        int k;
        is_key = !m_multi && (m_sweep.size() == 1);
        k = is_key ? m_sweep[0] : -1;
        if (!m_held) begin
            if (is_key) begin
                if (m_streak_len > 0 && k == m_streak_key) m_streak_len++;
                else begin m_streak_key = k; m_streak_len = 1; end
                if (m_streak_len >= DEB) begin
                    m_held = 1; exp_code = 4'(k); exp_valid = 1;
                    exp_q.push_back(4'(k)); m_confirms++;
                    m_rel = 0; m_streak_len = 0;
                end
            end else m_streak_len = 0;
        end else begin
            if (is_key && k == int'(exp_code)) m_rel = 0;
            else if (is_key) m_rel = (m_rel == 0) ? 1 : 0;
            else begin
                m_rel++;
                if (m_rel >= DEB) begin m_held = 0; m_rel = 0; m_streak_len = 0; end
            end
        end
        m_sweep.delete();
        m_multi = 0;
    endtask

    task automatic model_step();
        int c, found, kc;
        exp_valid = 0;
        m_e++;
        if (m_e % SD == 0) begin
            c = ((m_e / SD) - 1) % 4;
            found = 0; kc = 0;
            for (int r = 0; r < 4; r++) if (m_p2[r*4+c]) begin found++; kc = r*4+c; end
            if (found >= 2) m_multi = 1;
            else if (found == 1) m_sweep.push_back(kc);
            if (c == 3) model_sweep_done();
        end
        m_p2 = m_p1;
        m_p1 = keys;
        exp_colsel = ~(4'd1 << ((m_e / SD) % 4));
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk_key or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // scoreboard: every clock, outputs against the model
    initial forever begin
        @(negedge clk_key);
        n_total++;
        if (col_sel !== exp_colsel) $display("FAIL col_sel t=%0t got %b exp %b", $time, col_sel, exp_colsel);
        else n_pass++;
        n_total++;
        if (key_valid !== exp_valid) $display("FAIL key_valid t=%0t got %b exp %b", $time, key_valid, exp_valid);
        else n_pass++;
        n_total++;
        if (key_held !== m_held) $display("FAIL key_held t=%0t got %b exp %b", $time, key_held, m_held);
        else n_pass++;
        n_total++;
        if (key_code !== exp_code) $display("FAIL key_code t=%0t got %0d exp %0d", $time, key_code, exp_code);
        else n_pass++;
        if (exp_valid && exp_q.size() > 0) begin
            logic [3:0] want;
            want = exp_q.pop_front();
            n_total++;
            if (key_code !== want) $display("FAIL pulse_code t=%0t got %0d exp %0d", $time, key_code, want);
            else n_pass++;
        end
    end

    // driver / observer
    task automatic observe(input int cycles, output int pulses, output int held_hi, output logic [3:0] pcode);
        pulses = 0; held_hi = 0; pcode = '0;
        repeat (cycles) begin
            @(negedge clk_key);
            if (key_valid === 1'b1) begin pulses++; pcode = key_code; end
            if (key_held === 1'b1) held_hi++;
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk_key);
        n_total++; if (col_sel !== 4'b1110) $display("FAIL rst_col got %b exp 1110", col_sel); else n_pass++;
        n_total++; if (key_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", key_valid); else n_pass++;
        n_total++; if (key_held !== 1'b0) $display("FAIL rst_held got %b exp 0", key_held); else n_pass++;
        n_total++; if (key_code !== 4'd0) $display("FAIL rst_code got %0d exp 0", key_code); else n_pass++;
        n_total++; if (dbg_state !== key_pkg::IDLE) $display("FAIL rst_state got %0d exp 0", dbg_state); else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_press();
        int p, h; logic [3:0] pc;
        keys = 16'(1 << 6);
        observe(8 * SWEEP, p, h, pc);
        n_total++; if (p != 1) $display("FAIL press_pulses got %0d exp 1", p); else n_pass++;
        n_total++; if (pc !== 4'd6) $display("FAIL press_code got %0d exp 6", pc); else n_pass++;
        n_total++; if (key_held !== 1'b1) $display("FAIL press_held got %b exp 1", key_held); else n_pass++;
    endtask

    task automatic test_release();
        int p, h; logic [3:0] pc;
        keys = '0;
        observe(2 * SWEEP, p, h, pc);
        n_total++; if (h != 2 * SWEEP) $display("FAIL gap_held got %0d exp %0d", h, 2 * SWEEP); else n_pass++;
        keys = 16'(1 << 6);
        observe(4 * SWEEP, p, h, pc);
        n_total++; if (p != 0) $display("FAIL repress_pulses got %0d exp 0", p); else n_pass++;
        n_total++; if (h != 4 * SWEEP) $display("FAIL repress_held got %0d exp %0d", h, 4 * SWEEP); else n_pass++;
        keys = '0;
        observe(6 * SWEEP, p, h, pc);
        n_total++; if (key_held !== 1'b0) $display("FAIL release_held got %b exp 0", key_held); else n_pass++;
        n_total++; if (h < 2 * SWEEP || h > 4 * SWEEP) $display("FAIL release_time got %0d exp 32..64", h); else n_pass++;
    endtask

    task automatic test_bounce();
        int p, h, tot; logic [3:0] pc, lastc;
        tot = 0; lastc = '0;
        for (int i = 0; i < 2 * SWEEP; i++) begin
            if (i % 5 == 0) keys = keys ^ 16'(1 << 12);
            @(negedge clk_key);
            if (key_valid === 1'b1) begin tot++; lastc = key_code; end
        end
        keys = 16'(1 << 12);
        observe(6 * SWEEP, p, h, pc);
        tot += p;
        if (p > 0) lastc = pc;
        n_total++; if (tot != 1) $display("FAIL bounce_pulses got %0d exp 1", tot); else n_pass++;
        n_total++; if (lastc !== 4'd12) $display("FAIL bounce_code got %0d exp 12", lastc); else n_pass++;
        keys = '0;
        observe(6 * SWEEP, p, h, pc);
    endtask

    task automatic test_multi();
        int p, h; logic [3:0] pc;
        keys = 16'((1 << 1) | (1 << 5));
        observe(6 * SWEEP, p, h, pc);
        n_total++; if (p != 0) $display("FAIL multi_pulses got %0d exp 0", p); else n_pass++;
        n_total++; if (h != 0) $display("FAIL multi_held got %0d exp 0", h); else n_pass++;
        keys = 16'(1 << 1);
        observe(6 * SWEEP, p, h, pc);
        n_total++; if (p != 1) $display("FAIL multi_rel_pulses got %0d exp 1", p); else n_pass++;
        n_total++; if (pc !== 4'd1) $display("FAIL multi_rel_code got %0d exp 1", pc); else n_pass++;
        keys = '0;
        observe(6 * SWEEP, p, h, pc);
    endtask

    task automatic test_switch();
        int p, h; logic [3:0] pc;
        keys = 16'(1 << 6);
        observe(6 * SWEEP, p, h, pc);
        n_total++; if (pc !== 4'd6 || p != 1) $display("FAIL switch_first got %0d/%0d exp 6/1", pc, p); else n_pass++;
        keys = 16'(1 << 9);
        observe(6 * SWEEP, p, h, pc);
        n_total++; if (p != 0) $display("FAIL switch_pulses got %0d exp 0", p); else n_pass++;
        n_total++; if (h != 6 * SWEEP) $display("FAIL switch_held got %0d exp %0d", h, 6 * SWEEP); else n_pass++;
        n_total++; if (key_code !== 4'd6) $display("FAIL switch_code got %0d exp 6", key_code); else n_pass++;
        keys = '0;
        observe(6 * SWEEP, p, h, pc);
        n_total++; if (key_held !== 1'b0) $display("FAIL switch_release got %b exp 0", key_held); else n_pass++;
        keys = 16'(1 << 9);
        observe(6 * SWEEP, p, h, pc);
        n_total++; if (pc !== 4'd9 || p != 1) $display("FAIL switch_nine got %0d/%0d exp 9/1", pc, p); else n_pass++;
        keys = '0;
        observe(6 * SWEEP, p, h, pc);
    endtask

    task automatic test_random();
        int p, h, seen, base; logic [3:0] pc;
        seen = 0; base = m_confirms;
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: keys = '0;
                1, 2: keys = 16'(1 << $urandom_range(0, 15));
                default: keys = 16'((1 << $urandom_range(0, 15)) | (1 << $urandom_range(0, 15)));
            endcase
            observe($urandom_range(4, 70), p, h, pc);
            seen += p;
        end
        keys = '0;
        observe(6 * SWEEP, p, h, pc);
        seen += p;
        n_total++; if (seen != m_confirms - base) $display("FAIL rand_pulses got %0d exp %0d", seen, m_confirms - base); else n_pass++;
        n_total++; if (key_held !== 1'b0) $display("FAIL rand_held got %b exp 0", key_held); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int p, h; logic [3:0] pc;
        keys = 16'(1 << 6);
        observe(6 * SWEEP + 7, p, h, pc);
        n_total++; if (key_code !== 4'd6 || key_held !== 1'b1) $display("FAIL pre_rst got %0d/%b exp 6/1", key_code, key_held); else n_pass++;
        @(posedge clk_key);
        #3 rst_n = 1'b0;
        #1;
        n_total++; if (col_sel !== 4'b1110) $display("FAIL mid_rst_col got %b exp 1110", col_sel); else n_pass++;
        n_total++; if (key_valid !== 1'b0) $display("FAIL mid_rst_valid got %b exp 0", key_valid); else n_pass++;
        n_total++; if (key_held !== 1'b0) $display("FAIL mid_rst_held got %b exp 0", key_held); else n_pass++;
        n_total++; if (key_code !== 4'd0) $display("FAIL mid_rst_code got %0d exp 0", key_code); else n_pass++;
        keys = '0;
        @(negedge clk_key);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_key);
        n_total++; if (col_sel !== 4'b1110) $display("FAIL restart_col0 got %b exp 1110", col_sel); else n_pass++;
        @(negedge clk_key);
        n_total++; if (col_sel !== 4'b1101) $display("FAIL restart_col1 got %b exp 1101", col_sel); else n_pass++;
        observe(2 * SWEEP, p, h, pc);
    endtask

    initial begin
        test_reset();
        test_press();
        test_release();
        test_bounce();
        test_multi();
        test_switch();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/key_scan.md
# key_scan

Multiplexed 4x4 matrix keypad scanner: the input-side counterpart of the team's multiplexed 4-digit seven-segment driver. It walks an active-low one-cold column strobe across the keypad and samples the four row lines for each column. Each full sweep is reduced to a single key result, which is debounced over consecutive sweeps. Each confirmed press is delivered as a 4-bit key code with a one-clock strobe, feeding the UART transmit path and the display digit registers.

## Interface
Parameters:
- SCAN_DIV, 1000: clocks each column stays active (dwell); legal range >= 4.
- DEBOUNCE, 4: consecutive identical sweeps required to confirm a press or a release; legal range 1..15.

Ports:
- CLK_key  input  1  sole clock; all state changes on its rising edge.
- RST_n  input  1  asynchronous, active-low reset; applied immediately, released synchronously by the integrator.
- row_in  input  4  keypad rows, active-low (external pull-ups), asynchronous to CLK_key.
- col_sel  output  4  column strobe, active-low one-cold; bit i drives column i.
- key_code  output  4  code of last confirmed key = row*4 + col.
- key_valid  output  1  one-clock pulse when key_code is updated with a new press.
- key_held  output  1  high from confirmed press until confirmed release.

## Operation
- row_in passes through a 2-flop synchronizer before any use.
- Dwell counter counts 0..SCAN_DIV-1. It wraps on the terminal count ("tick").
- On each tick, col_sel rotates in this order: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
- The synchronized rows are sampled on the tick clock, i.e. the last clock of the dwell, before the column advances.
- Sweep accumulator, per column sample:
  - no row low: nothing is added.
  - exactly one row low: that key is recorded.
  - two or more rows low: the sweep is marked MULTI.
- Sweep result is evaluated at the tick of column 3:
  - NONE: no key recorded.
  - KEY(k): exactly one key recorded in the sweep.
  - MULTI: more than one key recorded, or any column marked MULTI. MULTI is treated as NONE for press detection.
- The accumulator clears after each evaluation.
- Debounce FSM advances once per sweep evaluation. It uses candidate register cand and counter cnt.
  - IDLE: KEY(k) -> PRESS_WAIT with cand=k, cnt=1. If DEBOUNCE=1, go directly to HELD instead.
  - PRESS_WAIT:
    - KEY(cand): cnt++.
    - When cnt reaches DEBOUNCE: go to HELD, key_code<=cand, key_valid=1 for one clock, key_held<=1.
    - KEY(j), j!=cand: cand=j, cnt=1.
    - NONE or MULTI: go to IDLE.
  - HELD:
    - KEY(key_code): stay.
    - NONE, MULTI, or a different key: go to RELEASE_WAIT with cnt=1. No new press is reported until release.
  - RELEASE_WAIT:
    - NONE or MULTI: cnt++. When cnt reaches DEBOUNCE: go to IDLE, key_held<=0.
    - Any KEY: return to HELD with no new key_valid.
- Reset (asynchronous, mid-operation included) forces:
  - col_sel=1110, key_code=0, key_valid=0, key_held=0.
  - dwell counter, accumulator, cand and cnt all = 0.
  - FSM = IDLE, synchronizer flops = 1111.

## Timing
- Sweep period = 4*SCAN_DIV clocks. Evaluation happens at column 3's tick.
- Press latency: a key stable before a sweep begins gives key_valid DEBOUNCE sweeps later, one clock after that sweep's evaluation tick.
- Release latency: DEBOUNCE clean sweeps, then key_held falls one clock after the evaluation tick.
- key_code is stable whenever key_valid is high and holds until the next confirmed press.
- Row settling: the 2-flop synchronizer plus sampling at end of dwell gives at least SCAN_DIV-3 clocks of settling after a column change.
- key_valid never asserts on consecutive clocks. At most one pulse occurs per DEBOUNCE sweeps.

## Structure
- Shared package key_pkg holds:
  - the FSM state encodings IDLE / PRESS_WAIT / HELD / RELEASE_WAIT;
  - the sweep-result encodings NONE / KEY / MULTI;
  - the column one-cold constants;
  - the key code width (4).
- Sub-module key_debounce contains the debounce FSM, cand and cnt. Its inputs are the sweep result and the evaluation strobe. It drives key_code, key_valid and key_held.
- Top level key_scan holds the synchronizer, dwell counter, column rotator and sweep accumulator.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE=3 (one sweep = 16 clocks).
- Reset mid-sweep -> col_sel=1110, key_valid=0, key_held=0, key_code=0 immediately, asynchronously to the clock. Sequence restarts at column 0.
- Press row 1 / col 2 held steady -> exactly one key_valid pulse after 3 evaluations with key_code=6 and key_held=1. No further pulses while held.
- Release after press -> key_held falls one clock after the 3rd clean evaluation. A 2-sweep gap followed by a re-press of the same key gives no new key_valid.
- Bounce: key toggles every 5 clocks for 2 sweeps, then holds row 3 / col 0 -> a single key_valid with key_code=12, 3 sweeps after the bouncing stops.
- Two keys pressed together (codes 1 and 5) -> MULTI every sweep, no key_valid, key_held stays 0. When key 5 is released, key_code=1 is confirmed after 3 sweeps.
- While HELD on key 6, switch directly to key 9 -> no key_valid. key_held drops only if 3 clean sweeps follow. After a proper release, pressing 9 gives key_code=9.
